// File: rtl/dispatch_buffer.sv
// Dispatch-side FIFO between rename and the issue queue write port.
// Waiting entries snoop the forwarding buses so no broadcast result is missed.
module dispatch_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_phys_rd,
  input  logic [5:0]       in_phys_rs1,
  input  logic [5:0]       in_phys_rs2,
  input  logic [31:0]      in_phys_rs1_val,
  input  logic [31:0]      in_phys_rs2_val,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [6:0]       in_opcode,
  input  logic [31:0]      in_immediate,
  input  logic [5:0]       in_ROB_entry_index,
  input  logic             fwd_enable,
  input  logic [5:0]       fwd_rd_funct_unit0,
  input  logic [5:0]       fwd_rd_funct_unit1,
  input  logic [5:0]       fwd_rd_funct_unit2,
  input  logic [5:0]       fwd_rd_mem,
  input  logic [31:0]      fwd_rd_val_funct_unit0,
  input  logic [31:0]      fwd_rd_val_funct_unit1,
  input  logic [31:0]      fwd_rd_val_funct_unit2,
  input  logic [31:0]      fwd_rd_val_mem,
  input  logic             issue_queue_full,
  output logic             write_enable,
  output logic [5:0]       phys_rd,
  output logic [5:0]       phys_rs1,
  output logic [5:0]       phys_rs2,
  output logic [31:0]      phys_rs1_val,
  output logic [31:0]      phys_rs2_val,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [6:0]       opcode,
  output logic [31:0]      immediate,
  output logic [5:0]       ROB_entry_index,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  op;
    logic [31:0] imm;
    logic [5:0]  rob;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   occ;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] slot_valid;
  logic [32:0]      rs1_fwd [DEPTH];
  logic [32:0]      rs2_fwd [DEPTH];
  logic [32:0]      in_rs1_fwd;
  logic [32:0]      in_rs2_fwd;
  logic [32:0]      head_rs1_fwd;
  logic [32:0]      head_rs2_fwd;
  entry_t           head;
  entry_t           incoming;

  // Returns {hit, value}; later assignments win, so unit0 has top priority.
  function automatic logic [32:0] fwd_lookup(input logic [5:0] tag);
    logic [32:0] r;
    r = '0;
    if (fwd_enable && tag != 6'd0) begin
      if (fwd_rd_mem == tag)         r = {1'b1, fwd_rd_val_mem};
      if (fwd_rd_funct_unit2 == tag) r = {1'b1, fwd_rd_val_funct_unit2};
      if (fwd_rd_funct_unit1 == tag) r = {1'b1, fwd_rd_val_funct_unit1};
      if (fwd_rd_funct_unit0 == tag) r = {1'b1, fwd_rd_val_funct_unit0};
    end
    return r;
  endfunction

  // Handshakes: rename pushes on in_valid && in_ready; the issue queue takes the
  // head whenever write_enable is high. in_ready never looks at issue_queue_full.
  assign in_ready     = occ < (PTR_W+1)'(DEPTH);
  assign write_enable = (occ != '0) && !issue_queue_full;
  assign push         = in_valid && in_ready;
  assign pop          = write_enable;
  assign count        = occ;
  assign head         = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = {1'b0, PTR_W'(i) - rd_ptr} < occ;
      rs1_fwd[i]    = fwd_lookup(mem[i].rs1);
      rs2_fwd[i]    = fwd_lookup(mem[i].rs2);
    end
  end

  always_comb begin
    in_rs1_fwd = fwd_lookup(in_phys_rs1);
    in_rs2_fwd = fwd_lookup(in_phys_rs2);
    incoming = '{rd: in_phys_rd, rs1: in_phys_rs1, rs2: in_phys_rs2,
                 rs1_val: in_rs1_fwd[32] ? in_rs1_fwd[31:0] : in_phys_rs1_val,
                 rs2_val: in_rs2_fwd[32] ? in_rs2_fwd[31:0] : in_phys_rs2_val,
                 f3: in_funct3, f7: in_funct7, op: in_opcode,
                 imm: in_immediate, rob: in_ROB_entry_index};
  end

  // Head operands see this cycle's broadcast even while being popped.
  always_comb begin
    head_rs1_fwd    = fwd_lookup(head.rs1);
    head_rs2_fwd    = fwd_lookup(head.rs2);
    phys_rd         = head.rd;
    phys_rs1        = head.rs1;
    phys_rs2        = head.rs2;
    phys_rs1_val    = head_rs1_fwd[32] ? head_rs1_fwd[31:0] : head.rs1_val;
    phys_rs2_val    = head_rs2_fwd[32] ? head_rs2_fwd[31:0] : head.rs2_val;
    funct3          = head.f3;
    funct7          = head.f7;
    opcode          = head.op;
    immediate       = head.imm;
    ROB_entry_index = head.rob;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid[i] && rs1_fwd[i][32]) mem[i].rs1_val <= rs1_fwd[i][31:0];
        if (slot_valid[i] && rs2_fwd[i][32]) mem[i].rs2_val <= rs2_fwd[i][31:0];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        // The write slot is never a valid entry, so it cannot collide with a snoop.
        if (push) begin
          mem[wr_ptr] <= incoming;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end
    end
  end

endmodule
